vga_sync_gen: RTL and testbench

Parametrised horizontal-plus-vertical VGA timing generator. It replaces the fixed 640x480 horizontal-only sync counter used in the Pong game.
- Produces pixel coordinates, hsync/vsync, video_on, line/frame end strobes and a frame-start pulse.
- Timing and sync polarity are set by parameters, so other display modes need no RTL change.
- Sits between the pixel-clock enable source and the pixel/graphics generators.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and helpers for axis totals and sync bounds.
package vga_timing_pkg;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CNT_W     = 11;
    localparam int unsigned DEF_TICK_DIV  = 4;

    function automatic int unsigned axis_total(input int unsigned display, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return display + front + sync + back;
    endfunction

    function automatic int unsigned sync_first(input int unsigned display, input int unsigned front);
        return display + front;
    endfunction

    function automatic int unsigned sync_last(input int unsigned display, input int unsigned front,
                                              input int unsigned sync);
        return display + front + sync - 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter with end decode and a registered sync output.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned LENGTH     = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 751,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_end,
    output logic             o_sync
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] S_START = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] S_END   = CNT_W'(SYNC_END);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_sync;
    logic             w_sync_next;

    assign o_count = r_count;
    assign o_sync  = r_sync;
    assign o_end   = (r_count == LAST);

    always_comb begin
        w_count_next = r_count;
        if (i_en) begin
            w_count_next = o_end ? '0 : r_count + CNT_W'(1);
        end
    end

    // NOTE: sync decodes the next count so the registered pulse lines up with the count itself.
    assign w_sync_next = ((w_count_next >= S_START) && (w_count_next <= S_END)) ? SYNC_POL : ~SYNC_POL;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_sync  <= ~SYNC_POL;
        end else begin
            r_count <= w_count_next;
            r_sync  <= w_sync_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA horizontal/vertical timing generator.
// Define VGA_TICK_DIV_EN to derive the pixel tick internally (one per TICK_DIV clocks) instead of p_tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             h_end,
    output logic             v_end,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start
);

    localparam int unsigned       H_TOTAL   = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned       V_TOTAL   = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned       MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam longint unsigned   CNT_RANGE = 64'd1 << CNT_W;

    if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
        $error("vga_sync_gen: porch and sync widths must be non-zero");
    end
    if (CNT_RANGE < 64'(MAX_TOTAL)) begin : g_bad_width
        $error("vga_sync_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: TICK_DIV must be at least 1");
    end

    logic w_tick;
    logic w_v_en;
    logic r_frame_start;

`ifdef VGA_TICK_DIV_EN
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             w_unused_p_tick;

    assign w_unused_p_tick = p_tick;
    assign w_tick          = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end
`else
    assign w_tick = p_tick;
`endif

    // The vertical axis steps once per line, on the tick that retires the last pixel.
    assign w_v_en = w_tick & h_end;

    vga_axis_counter #(
        .LENGTH     (H_TOTAL),
        .SYNC_START (sync_first(H_DISPLAY, H_FRONT)),
        .SYNC_END   (sync_last(H_DISPLAY, H_FRONT, H_SYNC)),
        .SYNC_POL   (HSYNC_POL),
        .CNT_W      (CNT_W)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_tick),
        .o_count (pixel_x),
        .o_end   (h_end),
        .o_sync  (hsync)
    );

    vga_axis_counter #(
        .LENGTH     (V_TOTAL),
        .SYNC_START (sync_first(V_DISPLAY, V_FRONT)),
        .SYNC_END   (sync_last(V_DISPLAY, V_FRONT, V_SYNC)),
        .SYNC_POL   (VSYNC_POL),
        .CNT_W      (CNT_W)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_v_en),
        .o_count (pixel_y),
        .o_end   (v_end),
        .o_sync  (vsync)
    );

    // Pulse lasts one clk even when the following clk carries no tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_en & v_end;
        end
    end

    assign frame_start = r_frame_start;
    assign video_on    = (pixel_x < CNT_W'(H_DISPLAY)) && (pixel_y < CNT_W'(V_DISPLAY));

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny-mode instance for whole-frame checks.
module tb_vga_sync_gen;

    localparam int HD = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int VD = 480, VF = 10, VS = 2,  VB = 33, VT = 525;
    localparam int SHD = 8, SHF = 2, SHS = 3, SHB = 2, SHT = 15;
    localparam int SVD = 6, SVF = 1, SVS = 2, SVB = 1, SVT = 10;
    localparam int TDIV = 4;
`ifdef VGA_TICK_DIV_EN
    localparam int CLKS_PER_LINE = TDIV * HT;
`else
    localparam int CLKS_PER_LINE = 2 * HT;
`endif

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        he;
        logic        ve;
        logic        hs;
        logic        vs;
        logic        von;
        logic        fs;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic [10:0] b_x, b_y;
    logic        b_he, b_ve, b_hs, b_vs, b_von, b_fs;
    logic [3:0]  s_x, s_y;
    logic        s_he, s_ve, s_hs, s_vs, s_von, s_fs;

    int   total = 0;
    int   bad   = 0;
    obs_t q_big[$];
    obs_t q_small[$];
    int   mx, my, sx, sy, mdiv;
    bit   mfs, sfs;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .reset(reset), .p_tick(p_tick),
        .pixel_x(b_x), .pixel_y(b_y), .h_end(b_he), .v_end(b_ve),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
    );

    vga_sync_gen #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(4), .TICK_DIV(TDIV)
    ) dut_s (
        .clk(clk), .reset(reset), .p_tick(p_tick),
        .pixel_x(s_x), .pixel_y(s_y), .h_end(s_he), .v_end(s_ve),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic obs_t expect_obs(input int x, input int y, input bit fs,
                                        input int hd, input int hf, input int hsw, input int ht,
                                        input int vd, input int vf, input int vsw, input int vt,
                                        input bit hpol, input bit vpol);
        obs_t o;
        o.x   = 11'(x);
        o.y   = 11'(y);
        o.he  = (x == ht - 1);
        o.ve  = (y == vt - 1);
        o.hs  = (x >= hd + hf && x <= hd + hf + hsw - 1) ? hpol : ~hpol;
        o.vs  = (y >= vd + vf && y <= vd + vf + vsw - 1) ? vpol : ~vpol;
        o.von = (x < hd) && (y < vd);
        o.fs  = fs;
        return o;
    endfunction

    // One clk: drive inputs, queue the model's expectation for both instances, then compare.
    task automatic step(input bit rst, input bit pt, output bit tk);
        obs_t eb, es, ob, os;
        reset  = rst;
        p_tick = pt;
`ifdef VGA_TICK_DIV_EN
        tk = !rst && (mdiv == TDIV - 1);
`else
        tk = !rst && pt;
`endif
        if (rst) begin
            mx = 0; my = 0; sx = 0; sy = 0; mfs = 0; sfs = 0; mdiv = 0;
        end else begin
            mdiv = (mdiv == TDIV - 1) ? 0 : mdiv + 1;
            mfs  = tk && mx == HT - 1 && my == VT - 1;
            sfs  = tk && sx == SHT - 1 && sy == SVT - 1;
            if (tk) begin
                if (mx == HT - 1) begin mx = 0; my = (my == VT - 1) ? 0 : my + 1; end
                else mx = mx + 1;
                if (sx == SHT - 1) begin sx = 0; sy = (sy == SVT - 1) ? 0 : sy + 1; end
                else sx = sx + 1;
            end
        end
        q_big.push_back(expect_obs(mx, my, mfs, HD, HF, HS, HT, VD, VF, VS, VT, 1'b0, 1'b0));
        q_small.push_back(expect_obs(sx, sy, sfs, SHD, SHF, SHS, SHT, SVD, SVF, SVS, SVT, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        eb = q_big.pop_front();
        es = q_small.pop_front();
        ob = '{x: b_x, y: b_y, he: b_he, ve: b_ve, hs: b_hs, vs: b_vs, von: b_von, fs: b_fs};
        os = '{x: 11'(s_x), y: 11'(s_y), he: s_he, ve: s_ve, hs: s_hs, vs: s_vs, von: s_von, fs: s_fs};
        total++;
        assert (ob === eb) else begin
            bad++;
            $error("FAIL cycle_big observed=%h expected=%h", ob, eb);
        end
        total++;
        assert (os === es) else begin
            bad++;
            $error("FAIL cycle_small observed=%h expected=%h", os, es);
        end
    endtask

    initial begin
        bit tk;
        bit hit;
        int n_he, n_hs, hs_first, hs_last, clks;
        int n_vs, n_von, n_fs, n_ve, vs_first, vs_last;

        reset  = 1'b1;
        p_tick = 1'b1;

        // Reset held three clks with p_tick high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, tk);
        check("rst_x", 32'(b_x), 0);
        check("rst_y", 32'(b_y), 0);
        check("rst_hsync", 32'(b_hs), 1);
        check("rst_vsync", 32'(b_vs), 1);
        check("rst_video_on", 32'(b_von), 1);
        check("rst_frame_start", 32'(b_fs), 0);
        check("rst_h_end", 32'(b_he), 0);
        check("rst_v_end", 32'(b_ve), 0);
        check("rst_small_hsync_pol", 32'(s_hs), 0);

        // One full line of ticks.
        n_he = 0; n_hs = 0; hs_first = -1; hs_last = -1;
        for (int t = 0; t < HT; ) begin
            step(1'b0, 1'b1, tk);
            if (tk) begin
                t++;
                if (b_he) n_he++;
                if (b_he) check("h_end_at_799", 32'(b_x), HT - 1);
                if (!b_hs) begin
                    n_hs++;
                    if (hs_first < 0) hs_first = int'(b_x);
                    hs_last = int'(b_x);
                end
            end
        end
        check("line_wrap_x", 32'(b_x), 0);
        check("line_wrap_y", 32'(b_y), 1);
        check("h_end_count", n_he, 1);
        check("hsync_width", n_hs, HS);
        check("hsync_first", hs_first, HD + HF);
        check("hsync_last", hs_last, HD + HF + HS - 1);

        // Toggling p_tick: the next line boundary is reached after a fixed number of clks.
        clks = 0; hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            step(1'b0, i[0], tk);
            clks++;
            if (b_x == 0 && b_y == 2) hit = 1;
        end
        check("toggle_line_reached", 32'(hit), 1);
        check("toggle_clks_per_line", clks, CLKS_PER_LINE);

        // Whole frame of the small instance, starting at its frame_start pulse.
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step(1'b0, 1'b1, tk);
            if (s_fs) hit = 1;
        end
        check("small_frame_start_seen", 32'(hit), 1);
        check("small_frame_origin_x", 32'(s_x), 0);
        check("small_frame_origin_y", 32'(s_y), 0);
        n_vs = 0; n_von = 0; n_fs = 0; n_ve = 0; vs_first = -1; vs_last = -1;
        for (int t = 0; t < SHT * SVT; ) begin
            step(1'b0, 1'b1, tk);
            if (s_fs) n_fs++;
            if (tk) begin
                t++;
                if (s_von) n_von++;
                if (s_ve) n_ve++;
                if (!s_vs) begin
                    n_vs++;
                    if (vs_first < 0) vs_first = int'(s_y);
                    vs_last = int'(s_y);
                end
            end
        end
        check("small_vsync_ticks", n_vs, SVS * SHT);
        check("small_vsync_first_line", vs_first, SVD + SVF);
        check("small_vsync_last_line", vs_last, SVD + SVF + SVS - 1);
        check("small_video_on_ticks", n_von, SHD * SVD);
        check("small_v_end_ticks", n_ve, SHT);
        check("small_frame_start_pulses", n_fs, 1);

        // Reset in the middle of hsync on the default instance.
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            step(1'b0, 1'b1, tk);
            if (b_x == 700) hit = 1;
        end
        check("reach_x700", 32'(hit), 1);
        check("x700_in_hsync", 32'(b_hs), 0);
        step(1'b1, 1'b1, tk);
        check("midrst_x", 32'(b_x), 0);
        check("midrst_y", 32'(b_y), 0);
        check("midrst_hsync", 32'(b_hs), 1);
        check("midrst_frame_start", 32'(b_fs), 0);
        check("midrst_small_hsync", 32'(s_hs), 0);
        for (int i = 0; i < 4 * TDIV; i++) step(1'b0, 1'b1, tk);
`ifdef VGA_TICK_DIV_EN
        check("post_rst_x", 32'(b_x), 4);
`else
        check("post_rst_x", 32'(b_x), 4 * TDIV);
`endif
        check("post_rst_frame_start", 32'(b_fs), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
